// File: rtl/ica_b_update_ctrl.sv
// Sequencing controller for the FastICA 4x4 W-register stage: init, per-row one-unit
// updates, decorrelation, commit and convergence check. Optional macro: ICA_HS_WATCHDOG_EN.
module ica_b_update_ctrl #(
    parameter int unsigned NUM_ROWS  = 4,
    parameter int unsigned MAX_ITER  = 64,
    parameter logic [25:0] THRESH    = 26'd8,
    parameter int unsigned WD_CYCLES = 1024
) (
    input  logic        clk_b,
    input  logic        rst_b,
    input  logic        start,
    input  logic        unit_done,
    input  logic [25:0] conv_metric,
    input  logic        ortho_done,
    output logic        unit_start,
    output logic [1:0]  unit_row,
    output logic        ortho_start,
    output logic        en_b,
    output logic        init_sel,
    output logic [7:0]  iter_cnt,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic        timeout,
    output logic        wd_err
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_ROW_GO    = 4'd2,
        ST_ROW_WAIT  = 4'd3,
        ST_ORTH_GO   = 4'd4,
        ST_ORTH_WAIT = 4'd5,
        ST_COMMIT    = 4'd6,
        ST_CHECK     = 4'd7,
        ST_FIN       = 4'd8
    } state_t;

    localparam logic [1:0] LAST_ROW   = 2'(NUM_ROWS - 1);
    localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

    state_t      state_q;
    logic [1:0]  row_q;
    logic [25:0] max_metric_q;
    logic [25:0] max_metric_d;
    logic [7:0]  iter_cnt_q;
    logic [7:0]  iter_cnt_d;
    logic        unit_start_q;
    logic        ortho_start_q;
    logic        en_b_q;
    logic        init_sel_q;
    logic        busy_q;
    logic        done_q;
    logic        converged_q;
    logic        timeout_q;
    logic        wd_hit_s;

    // Running worst-row metric and saturating iteration count.
    always_comb begin
        max_metric_d = max_metric_q;
        iter_cnt_d   = iter_cnt_q;
        if (conv_metric > max_metric_q) begin
            max_metric_d = conv_metric;
        end else begin
            max_metric_d = max_metric_q;
        end
        if (iter_cnt_q == MAX_ITER_C) begin
            iter_cnt_d = iter_cnt_q;
        end else begin
            iter_cnt_d = iter_cnt_q + 8'd1;
        end
    end

`ifdef ICA_HS_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WD_CYCLES - 1);

    logic [15:0] wd_cnt_q;
    logic        wd_err_q;
    logic        wd_hold_s;

    // A wait state that is not being released this cycle keeps the watchdog running.
    always_comb begin
        wd_hold_s = 1'b0;
        if (state_q == ST_ROW_WAIT) begin
            wd_hold_s = !unit_done;
        end else if (state_q == ST_ORTH_WAIT) begin
            wd_hold_s = !ortho_done;
        end else begin
            wd_hold_s = 1'b0;
        end
        wd_hit_s = wd_hold_s && (wd_cnt_q == WD_LAST);
    end

    // Wait-cycle counter, cleared on any state change.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            wd_cnt_q <= 16'd0;
        end else if (wd_hold_s && !wd_hit_s) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end else begin
            wd_cnt_q <= 16'd0;
        end
    end

    // Sticky watchdog flag, cleared when a new solve is accepted.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            wd_err_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            wd_err_q <= 1'b0;
        end else if (wd_hit_s) begin
            wd_err_q <= 1'b1;
        end else begin
            wd_err_q <= wd_err_q;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_hit_s = 1'b0;
    assign wd_err   = 1'b0;
`endif

    // Main sequencer; pulse outputs default low and are raised on entry to their state.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            state_q       <= ST_IDLE;
            row_q         <= 2'd0;
            max_metric_q  <= 26'd0;
            iter_cnt_q    <= 8'd0;
            unit_start_q  <= 1'b0;
            ortho_start_q <= 1'b0;
            en_b_q        <= 1'b0;
            init_sel_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            converged_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            unit_start_q  <= 1'b0;
            ortho_start_q <= 1'b0;
            en_b_q        <= 1'b0;
            init_sel_q    <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_INIT;
                        en_b_q      <= 1'b1;
                        init_sel_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        converged_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        iter_cnt_q  <= 8'd0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INIT: begin
                    state_q      <= ST_ROW_GO;
                    row_q        <= 2'd0;
                    max_metric_q <= 26'd0;
                    unit_start_q <= 1'b1;
                end
                ST_ROW_GO: begin
                    state_q <= ST_ROW_WAIT;
                end
                ST_ROW_WAIT: begin
                    if (unit_done) begin
                        max_metric_q <= max_metric_d;
                        if (row_q == LAST_ROW) begin
                            state_q       <= ST_ORTH_GO;
                            ortho_start_q <= 1'b1;
                        end else begin
                            row_q        <= row_q + 2'd1;
                            state_q      <= ST_ROW_GO;
                            unit_start_q <= 1'b1;
                        end
                    end else if (wd_hit_s) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ROW_WAIT;
                    end
                end
                ST_ORTH_GO: begin
                    state_q <= ST_ORTH_WAIT;
                end
                ST_ORTH_WAIT: begin
                    if (ortho_done) begin
                        state_q    <= ST_COMMIT;
                        en_b_q     <= 1'b1;
                        iter_cnt_q <= iter_cnt_d;
                    end else if (wd_hit_s) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ORTH_WAIT;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Convergence wins over timeout when both hold on the last iteration.
                    if (max_metric_q <= THRESH) begin
                        converged_q <= 1'b1;
                        state_q     <= ST_FIN;
                        done_q      <= 1'b1;
                    end else if (iter_cnt_q == MAX_ITER_C) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_FIN;
                        done_q    <= 1'b1;
                    end else begin
                        row_q        <= 2'd0;
                        max_metric_q <= 26'd0;
                        state_q      <= ST_ROW_GO;
                        unit_start_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign unit_start  = unit_start_q;
    assign unit_row    = row_q;
    assign ortho_start = ortho_start_q;
    assign en_b        = en_b_q;
    assign init_sel    = init_sel_q;
    assign iter_cnt    = iter_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ica_b_update_ctrl.sv
// Self-checking bench for ica_b_update_ctrl: directed table, randomized solves against a
// transaction-level model, reset abort and (with ICA_HS_WATCHDOG_EN) watchdog expiry.
`timescale 1ns/1ps
module tb_ica_b_update_ctrl;

    localparam int          ROWS = 4;
    localparam int          MAXI = 3;
    localparam logic [25:0] THR  = 26'd8;
    localparam int          WDC  = 16;

    logic        clk_b = 1'b0;
    logic        rst_b;
    logic        start;
    logic        unit_done;
    logic [25:0] conv_metric;
    logic        ortho_done;
    logic        unit_start;
    logic [1:0]  unit_row;
    logic        ortho_start;
    logic        en_b;
    logic        init_sel;
    logic [7:0]  iter_cnt;
    logic        busy;
    logic        done;
    logic        converged;
    logic        timeout;
    logic        wd_err;

    int checks   = 0;
    int failures = 0;

    logic [25:0] metric_tab [MAXI][ROWS];
    int          du_tab     [MAXI][ROWS];
    int          do_tab     [MAXI];

    typedef struct packed {
        logic [3:0][25:0] m_first;
        logic [25:0]      m_rest;
        logic [25:0]      m_last;
        logic [7:0]       exp_iter;
        logic             exp_conv;
        logic             exp_tmo;
    } vec_t;

    vec_t vecs [8];

    ica_b_update_ctrl #(
        .NUM_ROWS (ROWS),
        .MAX_ITER (MAXI),
        .THRESH   (THR),
        .WD_CYCLES(WDC)
    ) dut (
        .clk_b      (clk_b),
        .rst_b      (rst_b),
        .start      (start),
        .unit_done  (unit_done),
        .conv_metric(conv_metric),
        .ortho_done (ortho_done),
        .unit_start (unit_start),
        .unit_row   (unit_row),
        .ortho_start(ortho_start),
        .en_b       (en_b),
        .init_sel   (init_sel),
        .iter_cnt   (iter_cnt),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .timeout    (timeout),
        .wd_err     (wd_err)
    );

    always #5 clk_b = ~clk_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [25:0] a, input logic [25:0] b, input logic [25:0] c,
                                   input logic [25:0] d, input logic [25:0] rest, input logic [25:0] last,
                                   input int k, input logic cv, input logic tm);
        vec_t v;
        v.m_first  = {d, c, b, a};
        v.m_rest   = rest;
        v.m_last   = last;
        v.exp_iter = 8'(k);
        v.exp_conv = cv;
        v.exp_tmo  = tm;
        return v;
    endfunction

    // Outcome of a solve from the metric table: iteration i converges if its worst row
    // metric is within threshold; otherwise the solve stops after MAXI iterations.
    function automatic void model(output int k, output logic cv, output logic tm, output int busy_cyc);
        k = 0; cv = 1'b0; tm = 1'b0;
        busy_cyc = 2;
        for (int i = 0; i < MAXI; i++) begin
            logic [25:0] worst;
            worst = 26'd0;
            for (int r = 0; r < ROWS; r++) begin
                if (metric_tab[i][r] > worst) worst = metric_tab[i][r];
                busy_cyc += 1 + du_tab[i][r];
            end
            busy_cyc += 1 + do_tab[i] + 2;
            k = i + 1;
            if (worst <= THR) begin
                cv = 1'b1;
                break;
            end
            if (k == MAXI) begin
                tm = 1'b1;
                break;
            end
        end
    endfunction

    task automatic chk_all_zero(input string nm);
        logic [21:0] v;
        v = {unit_start, unit_row, ortho_start, en_b, init_sel, iter_cnt, busy, done,
             converged, timeout, wd_err, 3'b000};
        chk(nm, 32'(v), 32'd0);
    endtask

    task automatic run_solve(input string nm, input int exp_k, input logic exp_cv, input logic exp_tm,
                             input int exp_busy, input bit noisy);
        int n_us = 0, n_os = 0, n_en = 0, n_en_init = 0, n_done = 0;
        int row_err = 0, init_err = 0, busy_cyc = 0, first_us = -1, cyc = 0;
        int pend_u = 0, pend_o = 0;
        logic [25:0] pend_m = 26'd0;
        bit o_out = 1'b0, fin = 1'b0;
        logic [7:0] it_d = 8'd0;
        logic cv_d = 1'b0, tm_d = 1'b0, wd_d = 1'b0;
        @(negedge clk_b);
        start = 1'b1;
        while (!fin && cyc < 2000) begin
            @(negedge clk_b);
            cyc++;
            unit_done  = 1'b0;
            ortho_done = 1'b0;
            start      = 1'b0;
            if (pend_u > 0) begin
                pend_u--;
                if (pend_u == 0) begin
                    unit_done   = 1'b1;
                    conv_metric = pend_m;
                end
            end
            if (pend_o > 0) begin
                pend_o--;
                if (pend_o == 0) begin
                    ortho_done = 1'b1;
                    o_out      = 1'b0;
                end
            end
            if (busy) busy_cyc++;
            if (unit_start) begin
                if (first_us < 0) first_us = cyc;
                if (int'(unit_row) != n_us % ROWS) row_err++;
                pend_u = du_tab[(n_us / ROWS) % MAXI][n_us % ROWS];
                pend_m = metric_tab[(n_us / ROWS) % MAXI][n_us % ROWS];
                n_us++;
            end
            if (ortho_start) begin
                pend_o = do_tab[n_os % MAXI];
                o_out  = 1'b1;
                n_os++;
            end
            if (en_b) begin
                n_en++;
                if (init_sel) n_en_init++;
            end
            if (init_sel && (!en_b || cyc != 1)) init_err++;
            if (done) begin
                n_done++;
                fin  = 1'b1;
                it_d = iter_cnt; cv_d = converged; tm_d = timeout; wd_d = wd_err;
            end
            if (noisy && busy && !fin) begin
                if (pend_u == 0 && !unit_done && $urandom_range(0, 3) == 0) begin
                    unit_done   = 1'b1;
                    conv_metric = 26'($urandom);
                end
                if (!o_out && !ortho_done && $urandom_range(0, 3) == 0) ortho_done = 1'b1;
                if ($urandom_range(0, 3) == 0) start = 1'b1;
            end
        end
        chk({nm, " done_seen"}, 32'(fin), 32'd1);
        @(negedge clk_b);
        start = 1'b0; unit_done = 1'b0; ortho_done = 1'b0;
        chk({nm, " busy_after"}, 32'(busy), 32'd0);
        chk({nm, " first_unit_start_lat"}, 32'(first_us), 32'd2);
        chk({nm, " unit_starts"}, 32'(n_us), 32'(exp_k * ROWS));
        chk({nm, " ortho_starts"}, 32'(n_os), 32'(exp_k));
        chk({nm, " en_b_pulses"}, 32'(n_en), 32'(exp_k + 1));
        chk({nm, " en_b_init"}, 32'(n_en_init), 32'd1);
        chk({nm, " row_seq_err"}, 32'(row_err), 32'd0);
        chk({nm, " init_sel_err"}, 32'(init_err), 32'd0);
        chk({nm, " done_pulses"}, 32'(n_done), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        chk({nm, " iter_cnt"}, 32'(it_d), 32'(exp_k));
        chk({nm, " converged"}, 32'(cv_d), 32'(exp_cv));
        chk({nm, " timeout"}, 32'(tm_d), 32'(exp_tm));
        chk({nm, " wd_err"}, 32'(wd_d), 32'd0);
    endtask

    task automatic idle_noise(input string nm);
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_b);
            unit_done   = 1'(i % 2);
            ortho_done  = 1'((i + 1) % 2);
            conv_metric = 26'($urandom);
            if (busy || en_b || unit_start || ortho_start || done) bad++;
        end
        @(negedge clk_b);
        unit_done = 1'b0; ortho_done = 1'b0;
        chk({nm, " idle_stray"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int k, bc;
        logic cv, tm;
        rst_b = 1'b1; start = 1'b0; unit_done = 1'b0; ortho_done = 1'b0; conv_metric = 26'd0;
        vecs[0] = mkvec(26'd3, 26'd3, 26'd3, 26'd3, 26'd3, 26'd3, 1, 1'b1, 1'b0);
        vecs[1] = mkvec(26'd100, 26'd100, 26'd100, 26'd100, 26'd100, 26'd100, 3, 1'b0, 1'b1);
        vecs[2] = mkvec(26'd2, 26'd50, 26'd2, 26'd2, 26'd2, 26'd2, 2, 1'b1, 1'b0);
        vecs[3] = mkvec(26'd8, 26'd8, 26'd8, 26'd8, 26'd8, 26'd8, 1, 1'b1, 1'b0);
        vecs[4] = mkvec(26'd8, 26'd8, 26'd8, 26'd9, 26'd0, 26'd0, 2, 1'b1, 1'b0);
        vecs[5] = mkvec(26'd0, 26'h3FFFFFF, 26'd0, 26'd0, 26'd1, 26'd1, 2, 1'b1, 1'b0);
        vecs[6] = mkvec(26'd9, 26'd9, 26'd9, 26'd9, 26'd9, 26'd9, 3, 1'b0, 1'b1);
        vecs[7] = mkvec(26'd100, 26'd100, 26'd100, 26'd100, 26'd100, 26'd4, 3, 1'b1, 1'b0);

        repeat (2) @(negedge clk_b);
        chk_all_zero("reset_state");
        rst_b = 1'b0;
        idle_noise("post_reset");

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < MAXI; i++) begin
                do_tab[i] = (v < 4) ? 1 : int'($urandom_range(1, 3));
                for (int r = 0; r < ROWS; r++) begin
                    du_tab[i][r] = (v < 4) ? 1 : int'($urandom_range(1, 3));
                    if (i == 0) metric_tab[i][r] = vecs[v].m_first[r];
                    else if (i == MAXI - 1) metric_tab[i][r] = vecs[v].m_last;
                    else metric_tab[i][r] = vecs[v].m_rest;
                end
            end
            model(k, cv, tm, bc);
            run_solve($sformatf("vec%0d", v), int'(vecs[v].exp_iter), vecs[v].exp_conv,
                      vecs[v].exp_tmo, bc, 1'b0);
        end
        idle_noise("after_table");

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < MAXI; i++) begin
                do_tab[i] = int'($urandom_range(1, 3));
                for (int r = 0; r < ROWS; r++) begin
                    du_tab[i][r] = int'($urandom_range(1, 3));
                    metric_tab[i][r] = ($urandom_range(0, 5) == 0) ? 26'($urandom)
                                                                   : 26'($urandom_range(0, 11));
                end
            end
            model(k, cv, tm, bc);
            run_solve($sformatf("rnd%0d", n), k, cv, tm, bc, 1'b1);
        end

        begin : reset_abort
            int cyc = 0, dn = 0;
            bit prev_us = 1'b0, hit = 1'b0;
            @(negedge clk_b);
            start = 1'b1;
            while (!hit && cyc < 50) begin
                @(negedge clk_b);
                cyc++;
                start = 1'b0;
                unit_done = prev_us;
                conv_metric = 26'd100;
                prev_us = unit_start;
                if (unit_start && unit_row == 2'd2) hit = 1'b1;
            end
            chk("abort_row2_reached", 32'(hit), 32'd1);
            @(negedge clk_b);
            unit_done = 1'b0;
            rst_b = 1'b1;
            @(negedge clk_b);
            chk_all_zero("abort_reset_state");
            rst_b = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_b);
                if (done || busy || en_b) dn++;
            end
            chk("abort_no_activity", 32'(dn), 32'd0);
        end
        for (int i = 0; i < MAXI; i++) begin
            do_tab[i] = 1;
            for (int r = 0; r < ROWS; r++) begin
                du_tab[i][r] = 1;
                metric_tab[i][r] = (i == 0) ? 26'd20 : 26'd5;
            end
        end
        model(k, cv, tm, bc);
        run_solve("after_abort", k, cv, tm, bc, 1'b0);

`ifdef ICA_HS_WATCHDOG_EN
        begin : watchdog
            int cyc = 0, us_cyc = -1, dn_cyc = -1, n_en = 0;
            logic wd_d = 1'b0, cv_d = 1'b0, tm_d = 1'b0;
            @(negedge clk_b);
            start = 1'b1;
            while (dn_cyc < 0 && cyc < 100) begin
                @(negedge clk_b);
                cyc++;
                start = 1'b0;
                if (unit_start && us_cyc < 0) us_cyc = cyc;
                if (en_b) n_en++;
                if (done) begin
                    dn_cyc = cyc; wd_d = wd_err; cv_d = converged; tm_d = timeout;
                end
            end
            chk("wd_done_latency", 32'(dn_cyc - us_cyc), 32'(WDC + 1));
            chk("wd_err_set", 32'(wd_d), 32'd1);
            chk("wd_en_b_only_init", 32'(n_en), 32'd1);
            chk("wd_converged", 32'(cv_d), 32'd0);
            chk("wd_timeout", 32'(tm_d), 32'd0);
        end
        @(negedge clk_b);
        chk("wd_busy_after", 32'(busy), 32'd0);
        model(k, cv, tm, bc);
        run_solve("after_wd", k, cv, tm, bc, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
